// File: rtl/countdown_timer_param_if.sv
// Control and display bundle for countdown_timer_param.
// master drives load/start/pause/penalty; slave reports the time.
interface countdown_timer_param_if #(
  parameter int MIN_W = 4
) ();
  logic             load;
  logic [MIN_W-1:0] load_min;
  logic [5:0]       load_sec;
  logic             start;
  logic             pause;
  logic             penalty;
  logic [5:0]       penalty_sec;
  logic [MIN_W-1:0] minutos;
  logic [5:0]       segundos;
  logic [3:0]       decimos;
  logic             running;
  logic             warning;
  logic             expired;
  logic             expired_pulse;
  logic             blink;

  modport master (
    output load, load_min, load_sec,
    output start, pause, penalty, penalty_sec,
    input  minutos, segundos, decimos,
    input  running, warning, expired,
    input  expired_pulse, blink
  );

  modport slave (
    input  load, load_min, load_sec,
    input  start, pause, penalty, penalty_sec,
    output minutos, segundos, decimos,
    output running, warning, expired,
    output expired_pulse, blink
  );
endinterface

// File: rtl/countdown_timer_param.sv
// Loadable min:sec.tenths countdown with pause, penalty and warning.
// Optional: define TIMER_BLINK_EN for the warning blink output.
module countdown_timer_param #(
  parameter int TICKS_PER_TENTH = 5000000,
  parameter int MIN_W           = 4,
  parameter int DEFAULT_MIN     = 3,
  parameter int DEFAULT_SEC     = 0,
  parameter int WARN_SEC        = 10
) (
  input logic clk,
  input logic reset_n,
  countdown_timer_param_if.slave bus
);

  localparam int MAXT = (2**MIN_W - 1) * 600 + 599;
  localparam int TW   = $clog2(MAXT + 1);
  localparam int PW   = $clog2(TICKS_PER_TENTH);

  localparam logic [PW-1:0] PRE_LAST = PW'(TICKS_PER_TENTH - 1);
  localparam logic [TW-1:0] K600     = TW'(600);
  localparam logic [TW-1:0] K10      = TW'(10);
  localparam logic [5:0]    WARN     = 6'(WARN_SEC);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_PAUS = 2'd2;
  localparam logic [1:0] S_EXP  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [MIN_W-1:0] min_q, min_d;
  logic [5:0]       sec_q, sec_d;
  logic [3:0]       ten_q, ten_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic             pulse_q, pulse_d;
  logic             warn_q;
  logic             dec_fire;

  logic [TW-1:0]    total, pen, res, rem;
  logic [MIN_W-1:0] pen_min;
  logic [5:0]       pen_sec, ld_sec;
  logic [3:0]       pen_ten;
  logic             tick, is_run;

  assign is_run = (state_q == S_RUN);
  assign tick   = is_run && (pre_q == PRE_LAST);
  assign ld_sec = (bus.load_sec > 6'd59) ? 6'd59 : bus.load_sec;

  // Remaining time in tenths and the saturated post-penalty value
  always_comb begin
    total = TW'(min_q) * K600 + TW'(sec_q) * K10 + TW'(ten_q);
    pen   = TW'(bus.penalty_sec) * K10;
    res   = (total > pen) ? (total - pen) : '0;
    rem   = res % K600;
    pen_min = MIN_W'(res / K600);
    pen_sec = 6'(rem / K10);
    pen_ten = 4'(rem % K10);
  end

  // Next-state: load > penalty > pause > start > tick
  always_comb begin
    state_d  = state_q;
    min_d    = min_q;
    sec_d    = sec_q;
    ten_d    = ten_q;
    pre_d    = pre_q;
    pulse_d  = 1'b0;
    dec_fire = 1'b0;
    if (bus.load) begin
      state_d = S_IDLE;
      min_d   = bus.load_min;
      sec_d   = ld_sec;
      ten_d   = 4'd0;
      pre_d   = '0;
    end else if (bus.penalty && state_q != S_EXP) begin
      min_d = pen_min;
      sec_d = pen_sec;
      ten_d = pen_ten;
      if (is_run) begin
        pre_d = tick ? '0 : pre_q + 1'b1;
        if (res == '0) begin
          state_d = S_EXP;
          pulse_d = 1'b1;
        end
      end
    end else if (bus.pause && is_run) begin
      state_d = S_PAUS;
    end else if (bus.start &&
                 (state_q == S_IDLE || state_q == S_PAUS)) begin
      state_d = S_RUN;
    end else if (is_run) begin
      if (total == '0) begin
        state_d = S_EXP;
        pulse_d = 1'b1;
      end else if (tick) begin
        pre_d    = '0;
        dec_fire = 1'b1;
        if (ten_q != 4'd0) begin
          ten_d = ten_q - 4'd1;
        end else begin
          ten_d = 4'd9;
          if (sec_q != 6'd0) begin
            sec_d = sec_q - 6'd1;
          end else begin
            sec_d = 6'd59;
            min_d = min_q - 1'b1;
          end
        end
        if (total == TW'(1)) begin
          state_d = S_EXP;
          pulse_d = 1'b1;
        end
      end else begin
        pre_d = pre_q + 1'b1;
      end
    end
  end

  // Timer state, value and prescaler registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      min_q   <= MIN_W'(DEFAULT_MIN);
      sec_q   <= 6'(DEFAULT_SEC);
      ten_q   <= 4'd0;
      pre_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      ten_q   <= ten_d;
      pre_q   <= pre_d;
      pulse_q <= pulse_d;
    end
  end

  // Warning lags the displayed value by one cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      warn_q <= 1'b0;
    end else begin
      warn_q <= (state_q != S_EXP) && (total != '0) &&
                (min_q == '0) && (sec_q < WARN);
    end
  end

`ifdef TIMER_BLINK_EN
  logic [2:0] bcnt_q;
  logic       blink_q;

  // Toggle every fifth decrement while warning in RUN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bcnt_q  <= 3'd0;
      blink_q <= 1'b0;
    end else if (warn_q && is_run) begin
      if (dec_fire) begin
        if (bcnt_q == 3'd4) begin
          bcnt_q  <= 3'd0;
          blink_q <= ~blink_q;
        end else begin
          bcnt_q <= bcnt_q + 3'd1;
        end
      end
    end else begin
      bcnt_q  <= 3'd0;
      blink_q <= 1'b0;
    end
  end

  assign bus.blink = blink_q;
`else
  assign bus.blink = 1'b0;
`endif

  assign bus.minutos       = min_q;
  assign bus.segundos      = sec_q;
  assign bus.decimos       = ten_q;
  assign bus.running       = is_run;
  assign bus.warning       = warn_q;
  assign bus.expired       = (state_q == S_EXP);
  assign bus.expired_pulse = pulse_q;

endmodule

// File: tb/tb_countdown_timer_param.sv
// Directed scoreboard bench for countdown_timer_param.
// TICKS_PER_TENTH=4, so one tenth every 4 clocks.
module tb_countdown_timer_param;
  localparam int MW = 4;
  localparam int SW = MW + 14;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  countdown_timer_param_if #(.MIN_W(MW)) bus ();

  countdown_timer_param #(
    .TICKS_PER_TENTH(4),
    .MIN_W(MW),
    .DEFAULT_MIN(3),
    .DEFAULT_SEC(0),
    .WARN_SEC(10)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string         tag;
    logic [SW-1:0] val;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input string tag,
                      input int m, input int s, input int t,
                      input bit r, input bit w,
                      input bit e, input bit p);
    exp_t x;
    x.tag = tag;
    x.val = {MW'(m), 6'(s), 4'(t), r, w, e, p};
    sb.push_back(x);
  endtask

  task automatic check();
    exp_t x;
    logic [SW-1:0] obs;
    obs = {bus.minutos, bus.segundos, bus.decimos,
           bus.running, bus.warning, bus.expired,
           bus.expired_pulse};
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++;
      $error("FAIL sb_empty observed=%h required=entry", obs);
    end else begin
      x = sb.pop_front();
      assert (obs === x.val) else begin
        n_bad++;
        $error("FAIL %s observed=%h expected=%h",
               x.tag, obs, x.val);
      end
    end
  endtask

  task automatic chk_blink(input string tag, input bit e);
    n_cmp++;
    assert (bus.blink === e) else begin
      n_bad++;
      $error("FAIL %s observed=%b expected=%b",
             tag, bus.blink, e);
    end
  endtask

  task automatic do_load(input int m, input int s);
    bus.load     = 1'b1;
    bus.load_min = MW'(m);
    bus.load_sec = 6'(s);
    cyc(1);
    bus.load = 1'b0;
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    cyc(1);
    bus.start = 1'b0;
  endtask

  task automatic do_pause();
    bus.pause = 1'b1;
    cyc(1);
    bus.pause = 1'b0;
  endtask

  task automatic do_pen(input int n);
    bus.penalty     = 1'b1;
    bus.penalty_sec = 6'(n);
    cyc(1);
    bus.penalty = 1'b0;
  endtask

  initial begin
    bit bexp;
    bus.load = 1'b0;
    bus.load_min = '0;
    bus.load_sec = '0;
    bus.start = 1'b0;
    bus.pause = 1'b0;
    bus.penalty = 1'b0;
    bus.penalty_sec = '0;

    // reset and default run
    #12;
    push("reset", 3, 0, 0, 0, 0, 0, 0);
    check();
    chk_blink("reset_blink", 1'b0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    push("start_def", 3, 0, 0, 1, 0, 0, 0);
    do_start();
    check();
    push("run40", 2, 59, 0, 1, 0, 0, 0);
    cyc(40);
    check();

    // load 0:01 and run to expiry
    push("load001", 0, 1, 0, 0, 0, 0, 0);
    do_load(0, 1);
    check();
    push("start001", 0, 1, 0, 1, 1, 0, 0);
    do_start();
    check();
    for (int k = 9; k >= 1; k--) begin
      push($sformatf("tenth%0d", k), 0, 0, k, 1, 1, 0, 0);
      cyc(4);
      check();
    end
    push("expire", 0, 0, 0, 0, 1, 1, 1);
    cyc(4);
    check();
    push("exp_hold", 0, 0, 0, 0, 0, 1, 0);
    cyc(1);
    check();
    push("exp_start", 0, 0, 0, 0, 0, 1, 0);
    do_start();
    cyc(2);
    check();

    // pause mid-prescaler at 1:00.5
    push("load101", 1, 1, 0, 0, 0, 0, 0);
    do_load(1, 1);
    check();
    do_start();
    push("at1005", 1, 0, 5, 1, 0, 0, 0);
    cyc(20);
    check();
    cyc(2);
    push("paused", 1, 0, 5, 0, 0, 0, 0);
    do_pause();
    check();
    push("pause100", 1, 0, 5, 0, 0, 0, 0);
    cyc(100);
    check();
    push("resume", 1, 0, 5, 1, 0, 0, 0);
    do_start();
    check();
    push("resume1", 1, 0, 5, 1, 0, 0, 0);
    cyc(1);
    check();
    push("resume2", 1, 0, 4, 1, 0, 0, 0);
    cyc(1);
    check();

    // penalties
    push("load005", 0, 5, 0, 0, 0, 0, 0);
    do_load(0, 5);
    check();
    push("start005", 0, 5, 0, 1, 1, 0, 0);
    do_start();
    check();
    push("pen_exp", 0, 0, 0, 0, 1, 1, 1);
    do_pen(10);
    check();
    push("pen_exp1", 0, 0, 0, 0, 0, 1, 0);
    cyc(1);
    check();
    push("load200", 2, 0, 0, 0, 0, 0, 0);
    do_load(2, 0);
    check();
    do_start();
    push("pause200", 2, 0, 0, 0, 0, 0, 0);
    do_pause();
    check();
    push("pen30", 1, 30, 0, 0, 0, 0, 0);
    do_pen(30);
    check();
    do_load(0, 20);
    push("pen_sat", 0, 0, 0, 0, 0, 0, 0);
    do_pen(30);
    check();
    push("idle_zero", 0, 0, 0, 0, 0, 0, 0);
    cyc(1);
    check();
    push("start_zero", 0, 0, 0, 1, 0, 0, 0);
    do_start();
    check();
    push("zero_exp", 0, 0, 0, 0, 0, 1, 1);
    cyc(1);
    check();

    // warning and blink
    do_load(0, 15);
    do_start();
    push("at099", 0, 9, 9, 1, 0, 0, 0);
    cyc(204);
    check();
    push("warn_rise", 0, 9, 9, 1, 1, 0, 0);
    cyc(1);
    check();
    chk_blink("blink_a", 1'b0);
    cyc(18);
    chk_blink("blink_b", 1'b0);
    cyc(1);
`ifdef TIMER_BLINK_EN
    bexp = 1'b1;
`else
    bexp = 1'b0;
`endif
    chk_blink("blink_c", bexp);

    // asynchronous reset between edges
    #3;
    reset_n = 1'b0;
    #1;
    push("async_rst", 3, 0, 0, 0, 0, 0, 0);
    check();
    chk_blink("rst_blink", 1'b0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    push("rst_hold", 3, 0, 0, 0, 0, 0, 0);
    cyc(2);
    check();

    // load beats penalty; seconds clamp to 59
    bus.load = 1'b1;
    bus.load_min = MW'(2);
    bus.load_sec = 6'd61;
    bus.penalty = 1'b1;
    bus.penalty_sec = 6'd10;
    push("load_win", 2, 59, 0, 0, 0, 0, 0);
    cyc(1);
    bus.load = 1'b0;
    bus.penalty = 1'b0;
    check();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/countdown_timer_param.md
Name: countdown_timer_param

Overview:
Parametrised successor to the single-use 3-minute bomb countdown. It adds a run-time loadable start value, start/pause control, time-penalty subtraction for wrong actions, a low-time warning and expiry pulse/level outputs. The block sits between the game FSM (start/pause/penalty/load) and the display driver (minutes/seconds/tenths digits). Clock rate and counter widths are parameters.

Parameters:
TICKS_PER_TENTH, 5000000, clk cycles per 0.1 s (50 MHz default); must be >= 2
MIN_W, 4, width of minutes field (max minutes = 2^MIN_W-1)
DEFAULT_MIN, 3, minutes loaded at reset
DEFAULT_SEC, 0, seconds loaded at reset (0..59)
WARN_SEC, 10, warning asserted when remaining time is nonzero and < WARN_SEC whole seconds

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous, active-low reset
load  input  1  one-cycle strobe: load load_min/load_sec, tenths=0, go IDLE
load_min  input  MIN_W  minutes to load
load_sec  input  6  seconds to load; values >59 clamp to 59
start  input  1  one-cycle strobe: IDLE/PAUSED -> RUN
pause  input  1  one-cycle strobe: RUN -> PAUSED
penalty  input  1  one-cycle strobe: subtract penalty_sec from remaining time
penalty_sec  input  6  penalty amount in whole seconds (0..63)
minutos  output  MIN_W  remaining minutes
segundos  output  6  remaining seconds 0..59
decimos  output  4  remaining tenths 0..9
running  output  1  high in RUN
warning  output  1  low-time warning level
expired  output  1  level, high in EXPIRED
expired_pulse  output  1  single-cycle pulse on entry to EXPIRED
blink  output  1  warning blink (see Optional Feature)

Behaviour:
- Reset (reset_n=0, async): minutos=DEFAULT_MIN, segundos=DEFAULT_SEC, decimos=0, prescaler=0, state IDLE; running, warning, expired, expired_pulse, blink all 0.
- States: IDLE (holds value), RUN (counts), PAUSED (holds value, prescaler held), EXPIRED (value 0:00.0, holds until load or reset).
- Per-cycle priority: load > penalty > pause > start > tick.
- load: any state -> IDLE; prescaler cleared; expired cleared. A load of 0:00 goes to IDLE, not EXPIRED; a later start with value 0 goes to EXPIRED on the next cycle.
- start: accepted in IDLE/PAUSED only; ignored in RUN/EXPIRED. running=1 from the cycle after the strobe.
- pause: accepted in RUN only; prescaler value is retained so resuming loses no partial tenth.
- Prescaler: in RUN, counts 0..TICKS_PER_TENTH-1. On terminal count it wraps to 0 and the time decrements by 0.1 s with borrow: tenths 0->9 borrows seconds, seconds 0->59 borrows minutes.
- First decrement occurs TICKS_PER_TENTH cycles after RUN entry from a cleared prescaler.
- Expiry: when a decrement yields 0:00.0, enter EXPIRED in that same cycle. expired=1 and expired_pulse=1 for exactly one cycle; running=0.
- Penalty: accepted in IDLE/RUN/PAUSED and ignored in EXPIRED. Remaining total (in tenths) minus penalty_sec*10 saturates at 0. Result is stored in normalised min/sec/tenths form. If the result is 0 and state is RUN, enter EXPIRED with the pulse. In IDLE/PAUSED a zero result just holds at 0.
- Penalty and tick in the same cycle: penalty is applied to the pre-tick value and the tick is consumed (prescaler still wraps).
- warning = (state != EXPIRED) && total != 0 && (minutos==0) && (segundos < WARN_SEC). It is registered and updates the cycle after the value changes.
- Internal arithmetic uses a total-tenths width sufficient for (2^MIN_W-1)*600+599, with no overflow.

Optional Feature:
TIMER_BLINK_EN
- Defined: blink toggles every 5 decrements (0.5 s) while warning=1 and state=RUN. It is forced to 0 otherwise and is 0 on reset.
- Not defined: blink is tied to 0 and no blink logic is synthesised.

Test Plan:
- Reset, DEFAULT 3:00.0, TICKS_PER_TENTH=4, start, run 40 cycles -> 2:59.0; expired=0, running=1.
- load 0:01, start, run -> decimos steps 9..0, expired_pulse exactly one cycle when 0:00.0 reached, expired stays 1, further starts ignored.
- RUN at 1:00.5, pause mid-prescaler for 100 cycles, then start -> value holds at 1:00.5 during pause; next decrement arrives after the remaining prescaler count, not a full period.
- RUN at 0:05.0, penalty_sec=10 -> 0:00.0 and EXPIRED with pulse; in PAUSED at 2:00.0, penalty_sec=30 -> 1:30.0 and stays PAUSED.
- load 0:15, WARN_SEC=10, start -> warning rises when segundos becomes 9; blink toggles every 20 cycles (TIMER_BLINK_EN defined) or stays 0 (undefined).
- reset_n asserted mid-RUN, asynchronously between clock edges -> outputs return to 3:00.0/IDLE immediately; load and penalty in the same cycle -> load wins.
